random_sampler: RTL
===================

RANDOM_SAMPLER -- requirements
Module: random_sampler

Interface
REQ-001 Parameter DEB_CYCLES, default 16: consecutive stable cycles required to accept a key level change (range 2..255).
REQ-002 Parameter SCAN_DIV, default 4: clocks per display digit slot (range 1..65535).
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 cq  input  4  free-running code from the upstream sequence generator; may change every cycle.
REQ-006 key  input  1  raw push-button level, active-high, may bounce.
REQ-007 seg  output  7  segment drive, active-low, bit order gfedcba.
REQ-008 an  output  4  digit enables, active-low, one-hot-low; an[0] is the rightmost digit.
REQ-009 latch_cnt  output  4  number of samples captured, saturating.
REQ-010 led_hit  output  1  high when the last capture equals the capture before it.
REQ-011 state  output  2  FSM state: IDLE=00, RUN=01, HOLD=10; 11 is never reached.

Function
REQ-012 Debounce: keep a debounced level deb, reset 0, and a counter of consecutive cycles where key != deb; the counter clears whenever key == deb; deb toggles on the cycle the counter would reach DEB_CYCLES.
REQ-013 press is a registered one-cycle pulse, asserted on the cycle after deb rises 0->1; deb falling generates nothing.
REQ-014 FSM: IDLE --press--> RUN; RUN --press--> HOLD with capture; HOLD --press--> RUN; no other transitions.
REQ-015 Capture: on the RUN->HOLD press cycle, cq is sampled and history shifts: h3<=h2, h2<=h1, h1<=h0, h0<=cq; all four entries are 4 bits.
REQ-016 latch_cnt increments by 1 per capture and saturates at 15; it does not wrap.
REQ-017 led_hit updates on each capture: 1 if the sampled cq equals h0 before the shift, otherwise 0; it holds between captures.
REQ-018 Captures occur only on RUN->HOLD; presses in IDLE or HOLD never modify history, latch_cnt or led_hit.
REQ-019 Scan: a divider counts 0..SCAN_DIV-1; on wrap, digit index d advances 0->1->2->3->0.
REQ-020 an is registered: an = ~(1<<d), updated on the cycle after d changes.
REQ-021 seg is registered in the same cycle as an.
REQ-022 In IDLE, every digit shows dash 0111111.
REQ-023 In RUN, digit0 shows live cq and digits 1..3 show h0..h2.
REQ-024 In HOLD, digits 0..3 show h0..h3.
REQ-025 Hex decode, 0..7: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000.
REQ-026 Hex decode, 8..F: 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
REQ-027 A press arriving on the same cycle as a scan wrap processes both; the display reflects the new state from the next seg/an update.

Reset
REQ-028 rst has priority over every other event, including press and scan wrap.
REQ-029 While rst=1 the block holds: state=IDLE, deb=0, debounce counter=0, press=0, h0..h3=0, latch_cnt=0, led_hit=0, divider=0, d=0, seg=1111111, an=1111.
REQ-030 After rst falls, the first seg/an update occurs on the second clock edge.
REQ-031 Reset applied mid-operation (any state, mid-debounce, mid-scan) discards all captured data; no partial capture occurs.

Verification
REQ-032 Reset: rst=1 for 2 cycles -> seg=1111111, an=1111, latch_cnt=0, led_hit=0, state=00.
REQ-033 Bounce: DEB_CYCLES=16, key toggling every 3 cycles for 60 cycles, then 0 -> press never asserted, state stays 00.
REQ-034 Capture: stable press -> state=01; hold cq=5; stable press -> state=10, h0=5, latch_cnt=1; when an=1110, seg=0010010.
REQ-035 Hit: from RUN capture cq=3, press to RUN, capture cq=3 again -> led_hit=1; a third capture of cq=6 -> led_hit=0.
REQ-036 Saturation: 17 RUN->HOLD captures -> latch_cnt=15 after the 15th and after the 17th; history holds the last four cq values in order.
REQ-037 Mid-operation reset: in HOLD with latch_cnt=4, rst=1 for 1 cycle -> state=00, latch_cnt=0, h0..h3=0, then all digits show 0111111 as scanned.

Source files
------------

// File: rtl/random_sampler.sv
// Captures a free-running 4-bit code on debounced key presses, keeps a 4-deep history, drives a 4-digit 7-seg display.
// Latency: press pulse 1 cycle after debounced rise; state/capture on the press cycle; seg/an registered 1 cycle after digit index.
// No backpressure: cq is sampled on the capture edge; key bounce is absorbed by the debouncer.
module random_sampler #(
    parameter int DEB_CYCLES = 16,
    parameter int SCAN_DIV   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cq,
    input  logic       key,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic [3:0] latch_cnt,
    output logic       led_hit,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10
    } state_t;

    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    state_t      st;
    logic [7:0]  deb_cnt;
    logic        deb;
    logic        deb_q;
    logic        press;
    logic [3:0]  h0, h1, h2, h3;
    logic [15:0] div;
    logic [1:0]  d;
    logic        started;
    logic [3:0]  digit_nib;
    logic        digit_dash;
    logic [6:0]  digit_seg;

    assign state = st;

    // Hex digit to active-low gfedcba segment pattern.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // Debounce: deb flips only after DEB_CYCLES consecutive cycles of disagreement with key.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb     <= 1'b0;
            deb_cnt <= 8'd0;
        end else if (key == deb) begin
            deb_cnt <= 8'd0;
        end else if (deb_cnt == 8'(DEB_CYCLES - 1)) begin
            deb     <= ~deb;
            deb_cnt <= 8'd0;
        end else begin
            deb_cnt <= deb_cnt + 8'd1;
        end
    end

    // Press: one-cycle pulse the cycle after the debounced level rises; falls are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_q <= 1'b0;
            press <= 1'b0;
        end else begin
            deb_q <= deb;
            press <= deb & ~deb_q;
        end
    end

    // Mode FSM with history capture on the RUN->HOLD press only.
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IDLE;
            h0        <= 4'd0;
            h1        <= 4'd0;
            h2        <= 4'd0;
            h3        <= 4'd0;
            latch_cnt <= 4'd0;
            led_hit   <= 1'b0;
        end else begin
            case (st)
                IDLE: if (press) st <= RUN;
                RUN: begin
                    if (press) begin
                        st      <= HOLD;
                        h3      <= h2;
                        h2      <= h1;
                        h1      <= h0;
                        h0      <= cq;
                        led_hit <= (cq == h0);
                        if (latch_cnt != 4'd15) latch_cnt <= latch_cnt + 4'd1;
                    end
                end
                HOLD: if (press) st <= RUN;
                default: st <= IDLE;
            endcase
        end
    end

    // Scan divider: digit index advances each time the divider wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            div <= 16'd0;
            d   <= 2'd0;
        end else if (div == 16'(SCAN_DIV - 1)) begin
            div <= 16'd0;
            d   <= d + 2'd1;
        end else begin
            div <= div + 16'd1;
        end
    end

    // Select what the currently scanned digit should show for the current mode.
    always_comb begin
        digit_nib  = 4'd0;
        digit_dash = 1'b0;
        case (st)
            RUN: begin
                case (d)
                    2'd0: digit_nib = cq;
                    2'd1: digit_nib = h0;
                    2'd2: digit_nib = h1;
                    default: digit_nib = h2;
                endcase
            end
            HOLD: begin
                case (d)
                    2'd0: digit_nib = h0;
                    2'd1: digit_nib = h1;
                    2'd2: digit_nib = h2;
                    default: digit_nib = h3;
                endcase
            end
            default: digit_dash = 1'b1;
        endcase
        digit_seg = digit_dash ? SEG_DASH : hex7(digit_nib);
    end

    // Display registers: the first edge after reset only arms them, so the first update lands on the second edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            started <= 1'b0;
            seg     <= SEG_OFF;
            an      <= 4'b1111;
        end else begin
            started <= 1'b1;
            if (started) begin
                an  <= ~(4'b0001 << d);
                seg <= digit_seg;
            end
        end
    end

endmodule
